// File: rtl/pulser_pkg.sv
// Shared types and default widths for the pulse burst generator and its
// tick-driven down-counters.
package pulser_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int NPULSE_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HIGH,
    LOW,
    FIN
  } state_t;

endpackage

// File: rtl/tick_downcounter.sv
// Loadable down-counter that decrements on tick and saturates at zero.
// Load takes priority over the tick decrement.
module tick_downcounter
  import pulser_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Tick-aligned burst generator: COUNT pulses of WIDTH ticks high separated by
// GAP ticks low. Defining PULSE_BURST_ABORT_EN adds an ABORT input.
//
// Handshake: START is a level sampled only in IDLE; the cycle it is seen the
// fields are latched and BUSY rises on the next edge. DONE is a one-cycle
// strobe that coincides with BUSY falling. No back-pressure exists.
module pulse_burst_gen
  import pulser_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int NPULSE_W = NPULSE_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TICK,
  input  logic                START,
  input  logic [CNT_W-1:0]    WIDTH,
  input  logic [CNT_W-1:0]    GAP,
  input  logic [NPULSE_W-1:0] COUNT,
`ifdef PULSE_BURST_ABORT_EN
  input  logic                ABORT,
`endif
  output logic                BUSY,
  output logic                PULSE,
  output logic                DONE
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      w_lat, g_lat;
  logic [NPULSE_W-1:0]   c_lat;
  logic [NPULSE_W-1:0]   rem_q, rem_d;
  logic                  pulse_d, busy_d, done_d;
  logic                  latch_en;
  logic                  w_load, w_dec, g_load, g_dec;
  logic                  w_zero, g_zero;
  logic [CNT_W-1:0]      w_cnt, g_cnt;
  logic [CNT_W-1:0]      w_reload, g_reload;
  logic                  abort_i;

`ifdef PULSE_BURST_ABORT_EN
  assign abort_i = ABORT;
`else
  assign abort_i = 1'b0;
`endif

  // A zero field behaves as one tick, so the reload value is max(x,1)-1.
  assign w_reload = (w_lat == '0) ? '0 : w_lat - 1'b1;
  assign g_reload = (g_lat == '0) ? '0 : g_lat - 1'b1;

  tick_downcounter #(.W(CNT_W)) u_wcnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (w_load),
    .load_val (w_reload),
    .tick     (w_dec),
    .cnt      (w_cnt),
    .zero     (w_zero)
  );

  tick_downcounter #(.W(CNT_W)) u_gcnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (g_load),
    .load_val (g_reload),
    .tick     (g_dec),
    .cnt      (g_cnt),
    .zero     (g_zero)
  );

  always_comb begin
    state_d  = state_q;
    pulse_d  = PULSE;
    busy_d   = BUSY;
    done_d   = 1'b0;
    rem_d    = rem_q;
    latch_en = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    g_load   = 1'b0;
    g_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          latch_en = 1'b1;
          busy_d   = 1'b1;
          state_d  = (COUNT == '0) ? FIN : ARM;
        end
      end
      ARM: begin
        if (abort_i) begin
          pulse_d = 1'b0;
          state_d = FIN;
        end else if (TICK) begin
          pulse_d = 1'b1;
          w_load  = 1'b1;
          rem_d   = c_lat;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (abort_i) begin
          pulse_d = 1'b0;
          state_d = FIN;
        end else if (TICK) begin
          if (!w_zero) begin
            w_dec = 1'b1;
          end else begin
            pulse_d = 1'b0;
            if (rem_q == NPULSE_W'(1)) begin
              state_d = FIN;
            end else begin
              g_load  = 1'b1;
              state_d = LOW;
            end
          end
        end
      end
      LOW: begin
        if (abort_i) begin
          pulse_d = 1'b0;
          state_d = FIN;
        end else if (TICK) begin
          if (!g_zero) begin
            g_dec = 1'b1;
          end else begin
            pulse_d = 1'b1;
            w_load  = 1'b1;
            if (rem_q != '0) rem_d = rem_q - 1'b1;
            state_d = HIGH;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      PULSE   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      rem_q   <= '0;
      w_lat   <= '0;
      g_lat   <= '0;
      c_lat   <= '0;
    end else begin
      state_q <= state_d;
      PULSE   <= pulse_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      rem_q   <= rem_d;
      if (latch_en) begin
        w_lat <= WIDTH;
        g_lat <= GAP;
        c_lat <= COUNT;
      end
    end
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen: records each burst cycle by cycle and
// compares run lengths, edge positions and strobes with hand-derived values.
module tb_pulse_burst_gen;

  localparam int NREC = 128;

  logic        CLK   = 1'b0;
  logic        RST   = 1'b0;
  logic        TICK  = 1'b0;
  logic        START = 1'b0;
  logic [15:0] WIDTH = '0;
  logic [15:0] GAP   = '0;
  logic [7:0]  COUNT = '0;
  logic        BUSY, PULSE, DONE;
`ifdef PULSE_BURST_ABORT_EN
  logic        ABORT = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int tick_period = 0;
  int tick_cnt    = 0;

  logic pulse_r [NREC];
  logic busy_r  [NREC];
  logic done_r  [NREC];
  logic tick_r  [NREC];

  int n_rise, first_rise, last_fall, done_idx, n_done;
  int hi_min, hi_max, lo_min, lo_max;
  bit busy_ok;

  pulse_burst_gen dut (
    .CLK   (CLK),
    .RST   (RST),
    .TICK  (TICK),
    .START (START),
    .WIDTH (WIDTH),
    .GAP   (GAP),
    .COUNT (COUNT),
`ifdef PULSE_BURST_ABORT_EN
    .ABORT (ABORT),
`endif
    .BUSY  (BUSY),
    .PULSE (PULSE),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are stable 1ns after the edge, and TICK for
  // the next edge is updated from the tick schedule.
  task automatic cyc();
    @(posedge CLK);
    #1;
    if (tick_period == 0) begin
      TICK = 1'b0;
    end else begin
      tick_cnt = (tick_cnt + 1) % tick_period;
      TICK = (tick_cnt == 0);
    end
  endtask

  task automatic set_tick(input int p);
    tick_period = p;
    tick_cnt    = 0;
    TICK        = (p != 0);
  endtask

  task automatic analyze(input int n);
    int   rs, fs;
    logic prev;
    n_rise = 0; first_rise = -1; last_fall = -1; done_idx = -1; n_done = 0;
    hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0;
    rs = 0; fs = -1;
    for (int i = 0; i < n; i++) begin
      prev = (i == 0) ? 1'b0 : pulse_r[i-1];
      if (pulse_r[i] === 1'b1 && prev === 1'b0) begin
        n_rise++;
        if (first_rise < 0) first_rise = i;
        if (fs >= 0) begin
          if (i - fs < lo_min) lo_min = i - fs;
          if (i - fs > lo_max) lo_max = i - fs;
        end
        rs = i;
      end
      if (pulse_r[i] === 1'b0 && prev === 1'b1) begin
        if (i - rs < hi_min) hi_min = i - rs;
        if (i - rs > hi_max) hi_max = i - rs;
        last_fall = i;
        fs = i;
      end
      if (done_r[i] === 1'b1) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
    end
    busy_ok = (done_idx > 0) && (busy_r[done_idx] === 1'b0);
    for (int i = 0; i < done_idx; i++) if (busy_r[i] !== 1'b1) busy_ok = 1'b0;
  endtask

  // Sample index i is the DUT state just after edge i; edge 0 samples START.
  task automatic run_burst(input int w, input int g, input int c, input logic on_tick,
                           input int restart_at, input int rst_at, input int abort_at,
                           input int ncyc);
    for (int k = 0; k < 8 && TICK !== on_tick; k++) cyc();
    WIDTH = 16'(w); GAP = 16'(g); COUNT = 8'(c);
    for (int i = 0; i < ncyc; i++) begin
      START = (i == 0) || (i == restart_at);
      RST   = (rst_at >= 0) && (i == rst_at || i == rst_at + 1);
`ifdef PULSE_BURST_ABORT_EN
      ABORT = (i == abort_at);
`endif
      tick_r[i] = TICK;
      cyc();
      pulse_r[i] = PULSE; busy_r[i] = BUSY; done_r[i] = DONE;
      WIDTH = 16'($urandom_range(0, 65535));
      GAP   = 16'($urandom_range(0, 65535));
      COUNT = 8'($urandom_range(0, 255));
    end
    START = 1'b0; RST = 1'b0;
`ifdef PULSE_BURST_ABORT_EN
    ABORT = 1'b0;
`else
    if (abort_at >= 0) $display("note: abort request ignored in this build");
`endif
    for (int i = ncyc; i < NREC; i++) begin
      pulse_r[i] = 1'b0; busy_r[i] = 1'b0; done_r[i] = 1'b0; tick_r[i] = 1'b0;
    end
    analyze(ncyc);
  endtask

  task automatic test_reset();
    RST = 1'b1; cyc(); cyc(); RST = 1'b0;
    total++; if (PULSE !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", PULSE); end
    total++; if (BUSY  !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    total++; if (DONE  !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", DONE); end
  endtask

  task automatic test_nominal();
    int exp_first;
    set_tick(4);
    run_burst(3, 2, 4, 1'b0, -1, -1, -1, 110);
    exp_first = -1;
    for (int j = 1; j < 110; j++) if (exp_first < 0 && tick_r[j] === 1'b1) exp_first = j;
    total++; if (n_rise != 4)    begin bad++; $display("FAIL nom_rises got=%0d exp=4", n_rise); end
    total++; if (hi_min != 12 || hi_max != 12) begin bad++; $display("FAIL nom_high got=%0d..%0d exp=12", hi_min, hi_max); end
    total++; if (lo_min != 8 || lo_max != 8)   begin bad++; $display("FAIL nom_low got=%0d..%0d exp=8", lo_min, lo_max); end
    total++; if (first_rise != exp_first) begin bad++; $display("FAIL nom_latency got=%0d exp=%0d", first_rise, exp_first); end
    total++; if (done_idx != last_fall + 1) begin bad++; $display("FAIL nom_done_pos got=%0d exp=%0d", done_idx, last_fall + 1); end
    total++; if (n_done != 1)    begin bad++; $display("FAIL nom_done_count got=%0d exp=1", n_done); end
    total++; if (!busy_ok)       begin bad++; $display("FAIL nom_busy got=0 exp=1"); end
  endtask

  task automatic test_zero_fields();
    set_tick(1);
    run_burst(0, 0, 3, 1'b1, -1, -1, -1, 20);
    total++; if (n_rise != 3)    begin bad++; $display("FAIL zero_rises got=%0d exp=3", n_rise); end
    total++; if (hi_min != 1 || hi_max != 1) begin bad++; $display("FAIL zero_high got=%0d..%0d exp=1", hi_min, hi_max); end
    total++; if (lo_min != 1 || lo_max != 1) begin bad++; $display("FAIL zero_low got=%0d..%0d exp=1", lo_min, lo_max); end
    total++; if (first_rise != 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", first_rise); end
    total++; if (done_idx != 7)  begin bad++; $display("FAIL zero_done_pos got=%0d exp=7", done_idx); end
    total++; if (!busy_ok)       begin bad++; $display("FAIL zero_busy got=0 exp=1"); end
    run_burst(5, 5, 0, 1'b1, -1, -1, -1, 10);
    total++; if (n_rise != 0)    begin bad++; $display("FAIL cnt0_rises got=%0d exp=0", n_rise); end
    total++; if (done_idx != 1)  begin bad++; $display("FAIL cnt0_done_pos got=%0d exp=1", done_idx); end
    total++; if (n_done != 1)    begin bad++; $display("FAIL cnt0_done_count got=%0d exp=1", n_done); end
    total++; if (busy_r[0] !== 1'b1 || busy_r[1] !== 1'b0) begin bad++; $display("FAIL cnt0_busy got=%b%b exp=10", busy_r[0], busy_r[1]); end
  endtask

  task automatic test_start_tick_coincide();
    set_tick(4);
    run_burst(2, 1, 3, 1'b1, 10, -1, -1, 60);
    total++; if (first_rise != 4) begin bad++; $display("FAIL coin_latency got=%0d exp=4", first_rise); end
    total++; if (n_rise != 3)    begin bad++; $display("FAIL coin_rises got=%0d exp=3", n_rise); end
    total++; if (hi_min != 8 || hi_max != 8) begin bad++; $display("FAIL coin_high got=%0d..%0d exp=8", hi_min, hi_max); end
    total++; if (lo_min != 4 || lo_max != 4) begin bad++; $display("FAIL coin_low got=%0d..%0d exp=4", lo_min, lo_max); end
    total++; if (done_idx != 37) begin bad++; $display("FAIL coin_done_pos got=%0d exp=37", done_idx); end
    total++; if (n_done != 1)    begin bad++; $display("FAIL coin_done_count got=%0d exp=1", n_done); end
    total++; if (!busy_ok)       begin bad++; $display("FAIL coin_busy got=0 exp=1"); end
  endtask

  task automatic test_reset_mid_burst();
    set_tick(4);
    run_burst(3, 2, 4, 1'b1, -1, 28, -1, 60);
    total++; if (pulse_r[27] !== 1'b1) begin bad++; $display("FAIL rstmid_pre_pulse got=%b exp=1", pulse_r[27]); end
    total++; if (pulse_r[28] !== 1'b0) begin bad++; $display("FAIL rstmid_pulse got=%b exp=0", pulse_r[28]); end
    total++; if (busy_r[28]  !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy_r[28]); end
    total++; if (n_done != 0)    begin bad++; $display("FAIL rstmid_done got=%0d exp=0", n_done); end
    total++; if (n_rise != 2)    begin bad++; $display("FAIL rstmid_rises got=%0d exp=2", n_rise); end
    run_burst(3, 2, 4, 1'b1, -1, -1, -1, 100);
    total++; if (n_rise != 4)    begin bad++; $display("FAIL rstnew_rises got=%0d exp=4", n_rise); end
    total++; if (first_rise != 4) begin bad++; $display("FAIL rstnew_latency got=%0d exp=4", first_rise); end
    total++; if (done_idx != 77) begin bad++; $display("FAIL rstnew_done_pos got=%0d exp=77", done_idx); end
    total++; if (!busy_ok)       begin bad++; $display("FAIL rstnew_busy got=0 exp=1"); end
  endtask

`ifdef PULSE_BURST_ABORT_EN
  task automatic test_abort();
    set_tick(4);
    run_burst(3, 2, 5, 1'b1, -1, -1, 20, 40);
    total++; if (n_rise != 1)    begin bad++; $display("FAIL abort_rises got=%0d exp=1", n_rise); end
    total++; if (done_idx != 21) begin bad++; $display("FAIL abort_done_pos got=%0d exp=21", done_idx); end
    total++; if (n_done != 1)    begin bad++; $display("FAIL abort_done_count got=%0d exp=1", n_done); end
    total++; if (busy_r[20] !== 1'b1 || busy_r[21] !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b%b exp=10", busy_r[20], busy_r[21]); end
    ABORT = 1'b1; cyc(); ABORT = 1'b0;
    total++; if (BUSY !== 1'b0)  begin bad++; $display("FAIL abort_idle_busy got=%b exp=0", BUSY); end
    cyc();
    total++; if (DONE !== 1'b0)  begin bad++; $display("FAIL abort_idle_done got=%b exp=0", DONE); end
  endtask
`endif

  initial begin
    set_tick(0);
    test_reset();
    test_nominal();
    test_zero_fields();
    test_start_tick_coincide();
    test_reset_mid_burst();
`ifdef PULSE_BURST_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
